// File: rtl/spu_reg_fetch.sv
// Register-file / operand-fetch stage: 128 x 128-bit register file, three bypassed
// operand reads, and the pipeline register that feeds the execute units.
module spu_reg_fetch (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:6]   ra_addr,
  input  logic [0:6]   rb_addr,
  input  logic [0:6]   rc_addr,
  input  logic [0:10]  op_in,
  input  logic [0:2]   format_in,
  input  logic [0:17]  imm_in,
  input  logic [0:6]   rt_addr_in,
  input  logic         reg_write_in,
  input  logic         stall,
  input  logic         flush,
  input  logic [0:127] rt_even_wb,
  input  logic [0:6]   rt_addr_even_wb,
  input  logic         reg_write_even_wb,
  input  logic [0:127] rt_odd_wb,
  input  logic [0:6]   rt_addr_odd_wb,
  input  logic         reg_write_odd_wb,
  output logic [0:127] ra,
  output logic [0:127] rb,
  output logic [0:127] rc,
  output logic [0:10]  op,
  output logic [0:2]   format,
  output logic [0:17]  imm,
  output logic [0:6]   rt_addr,
  output logic         reg_write,
  output logic         wb_conflict
);

  logic [0:127] rf [0:127];

  // Source addresses of the instruction currently held in the output register.
  logic [0:6] ra_src_q, rb_src_q, rc_src_q;

  logic [0:6]   ra_sel, rb_sel, rc_sel;
  logic [0:127] ra_byp, rb_byp, rc_byp;

  // Odd pipe is later in program order, so its writeback takes precedence.
  function automatic logic [0:127] bypass(input logic [0:6] addr);
    logic [0:127] val;
    val = rf[addr];
    if (reg_write_even_wb && (rt_addr_even_wb == addr)) val = rt_even_wb;
    if (reg_write_odd_wb && (rt_addr_odd_wb == addr)) val = rt_odd_wb;
    return val;
  endfunction

  // A stalled instruction keeps re-reading its own sources so operands never go stale.
  always_comb begin
    ra_sel = stall ? ra_src_q : ra_addr;
    rb_sel = stall ? rb_src_q : rb_addr;
    rc_sel = stall ? rc_src_q : rc_addr;
    ra_byp = bypass(ra_sel);
    rb_byp = bypass(rb_sel);
    rc_byp = bypass(rc_sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) rf[i] <= '0;
    end else begin
      if (reg_write_even_wb) rf[rt_addr_even_wb] <= rt_even_wb;
      if (reg_write_odd_wb)  rf[rt_addr_odd_wb]  <= rt_odd_wb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_conflict <= 1'b0;
    end else begin
      wb_conflict <= reg_write_even_wb && reg_write_odd_wb &&
                     (rt_addr_even_wb == rt_addr_odd_wb);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
      op        <= '0;
      format    <= '0;
      imm       <= '0;
      rt_addr   <= '0;
      reg_write <= 1'b0;
      ra_src_q  <= '0;
      rb_src_q  <= '0;
      rc_src_q  <= '0;
    end else if (flush) begin
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
      op        <= '0;
      format    <= '0;
      imm       <= '0;
      rt_addr   <= '0;
      reg_write <= 1'b0;
      ra_src_q  <= '0;
      rb_src_q  <= '0;
      rc_src_q  <= '0;
    end else if (stall) begin
      ra <= ra_byp;
      rb <= rb_byp;
      rc <= rc_byp;
    end else begin
      ra        <= ra_byp;
      rb        <= rb_byp;
      rc        <= rc_byp;
      op        <= op_in;
      format    <= format_in;
      imm       <= imm_in;
      rt_addr   <= rt_addr_in;
      reg_write <= reg_write_in;
      ra_src_q  <= ra_addr;
      rb_src_q  <= rb_addr;
      rc_src_q  <= rc_addr;
    end
  end

endmodule

// File: tb/tb_spu_reg_fetch.sv
// Bench for spu_reg_fetch: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a register-state reference model.
module tb_spu_reg_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:6]   ra_addr, rb_addr, rc_addr;
  logic [0:10]  op_in;
  logic [0:2]   format_in;
  logic [0:17]  imm_in;
  logic [0:6]   rt_addr_in;
  logic         reg_write_in;
  logic         stall, flush;
  logic [0:127] rt_even_wb, rt_odd_wb;
  logic [0:6]   rt_addr_even_wb, rt_addr_odd_wb;
  logic         reg_write_even_wb, reg_write_odd_wb;
  logic [0:127] ra, rb, rc;
  logic [0:10]  op;
  logic [0:2]   format;
  logic [0:17]  imm;
  logic [0:6]   rt_addr;
  logic         reg_write;
  logic         wb_conflict;

  spu_reg_fetch dut (
    .clk(clk), .reset(reset),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .op_in(op_in), .format_in(format_in), .imm_in(imm_in),
    .rt_addr_in(rt_addr_in), .reg_write_in(reg_write_in),
    .stall(stall), .flush(flush),
    .rt_even_wb(rt_even_wb), .rt_addr_even_wb(rt_addr_even_wb),
    .reg_write_even_wb(reg_write_even_wb),
    .rt_odd_wb(rt_odd_wb), .rt_addr_odd_wb(rt_addr_odd_wb),
    .reg_write_odd_wb(reg_write_odd_wb),
    .ra(ra), .rb(rb), .rc(rc), .op(op), .format(format), .imm(imm),
    .rt_addr(rt_addr), .reg_write(reg_write), .wb_conflict(wb_conflict)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:127] ra;
    logic [0:127] rb;
    logic [0:127] rc;
    logic [0:10]  op;
    logic [0:2]   fmt;
    logic [0:17]  imm;
    logic [0:6]   rt;
    logic         rw;
    logic         conf;
  } out_t;

  out_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents plus the held instruction.
  logic [0:127] mem [128];
  out_t         cur;
  logic [0:6]   sa, sb, sc;

  localparam logic [0:127] PAT_A5 = {16{8'hA5}};
  localparam logic [0:127] PAT_11 = {16{8'h11}};
  localparam logic [0:127] PAT_22 = {16{8'h22}};
  localparam logic [0:127] PAT_FF = {16{8'hFF}};

  task automatic chk(input string name, input logic [0:127] act, input logic [0:127] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    ra_addr = '0; rb_addr = '0; rc_addr = '0;
    op_in = '0; format_in = '0; imm_in = '0; rt_addr_in = '0; reg_write_in = 1'b0;
    stall = 1'b0; flush = 1'b0;
    rt_even_wb = '0; rt_addr_even_wb = '0; reg_write_even_wb = 1'b0;
    rt_odd_wb = '0; rt_addr_odd_wb = '0; reg_write_odd_wb = 1'b0;
  endtask

  task automatic rand_fields();
    op_in = 11'($urandom()); format_in = 3'($urandom()); imm_in = 18'($urandom());
    rt_addr_in = 7'($urandom()); reg_write_in = 1'($urandom());
  endtask

  // Predict the output register after the coming edge, queue it, then let the edge pass.
  task automatic step();
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      cur = '0;
      sa = '0; sb = '0; sc = '0;
    end else begin
      cur.conf = reg_write_even_wb && reg_write_odd_wb && (rt_addr_even_wb == rt_addr_odd_wb);
      if (reg_write_even_wb) mem[rt_addr_even_wb] = rt_even_wb;
      if (reg_write_odd_wb)  mem[rt_addr_odd_wb]  = rt_odd_wb;
      if (flush) begin
        cur.ra = '0; cur.rb = '0; cur.rc = '0;
        cur.op = '0; cur.fmt = '0; cur.imm = '0; cur.rt = '0; cur.rw = 1'b0;
        sa = '0; sb = '0; sc = '0;
      end else if (stall) begin
        cur.ra = mem[sa]; cur.rb = mem[sb]; cur.rc = mem[sc];
      end else begin
        sa = ra_addr; sb = rb_addr; sc = rc_addr;
        cur.ra = mem[sa]; cur.rb = mem[sb]; cur.rc = mem[sc];
        cur.op = op_in; cur.fmt = format_in; cur.imm = imm_in;
        cur.rt = rt_addr_in; cur.rw = reg_write_in;
      end
    end
    exp_q.push_back(cur);
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_ra", ra, e.ra);
        chk("sb_rb", rb, e.rb);
        chk("sb_rc", rc, e.rc);
        chk("sb_op", 128'(op), 128'(e.op));
        chk("sb_format", 128'(format), 128'(e.fmt));
        chk("sb_imm", 128'(imm), 128'(e.imm));
        chk("sb_rt_addr", 128'(rt_addr), 128'(e.rt));
        chk("sb_reg_write", 128'(reg_write), 128'(e.rw));
        chk("sb_wb_conflict", 128'(wb_conflict), 128'(e.conf));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ra"}, ra, '0);
    chk({tag, "_rb"}, rb, '0);
    chk({tag, "_rc"}, rc, '0);
    chk({tag, "_fields"}, 128'({op, format, imm, rt_addr, reg_write, wb_conflict}), '0);
  endtask

  // ---------------- stimulus ----------------
  logic [0:10]  held_op;
  logic [0:17]  held_imm;
  logic [0:6]   held_rt;
  logic [0:127] wb_data [$];
  logic [0:6]   wb_addr [$];
  logic         wb_vld  [$];

  initial begin
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    cur = '0; sa = '0; sb = '0; sc = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset_init");
    reset = 1'b0;

    // Write then read
    rt_even_wb = PAT_A5; rt_addr_even_wb = 7'd5; reg_write_even_wb = 1'b1;
    step();
    idle_inputs();
    ra_addr = 7'd5; rb_addr = 7'd6;
    step();
    chk("wr_rd_ra", ra, PAT_A5);
    chk("wr_rd_rb", rb, '0);

    // Same-cycle dual writeback to one register
    idle_inputs();
    rt_even_wb = PAT_11; rt_addr_even_wb = 7'd9; reg_write_even_wb = 1'b1;
    rt_odd_wb  = PAT_22; rt_addr_odd_wb  = 7'd9; reg_write_odd_wb  = 1'b1;
    rc_addr = 7'd9;
    step();
    chk("bypass_rc", rc, PAT_22);
    chk("conflict_set", 128'(wb_conflict), 128'(1));
    idle_inputs();
    rc_addr = 7'd9;
    step();
    chk("conflict_clear", 128'(wb_conflict), '0);
    chk("array_rc", rc, PAT_22);

    // Stall refresh
    idle_inputs();
    rand_fields();
    ra_addr = 7'd3;
    held_op = op_in; held_imm = imm_in; held_rt = rt_addr_in;
    step();
    chk("stall_pre_ra", ra, '0);
    rand_fields();
    ra_addr = 7'd7;
    stall = 1'b1;
    rt_odd_wb = PAT_FF; rt_addr_odd_wb = 7'd3; reg_write_odd_wb = 1'b1;
    step();
    chk("stall_ra", ra, PAT_FF);
    chk("stall_op", 128'(op), 128'(held_op));
    chk("stall_imm", 128'(imm), 128'(held_imm));
    chk("stall_rt", 128'(rt_addr), 128'(held_rt));
    idle_inputs();
    rand_fields();
    ra_addr = 7'd5;
    held_op = op_in;
    step();
    chk("unstall_op", 128'(op), 128'(held_op));
    chk("unstall_ra", ra, PAT_A5);

    // Flush beats stall; writeback in the same cycle still commits
    idle_inputs();
    stall = 1'b1; flush = 1'b1;
    op_in = 11'b00001011111; reg_write_in = 1'b1; ra_addr = 7'd5;
    rt_even_wb = PAT_11; rt_addr_even_wb = 7'd20; reg_write_even_wb = 1'b1;
    step();
    chk("flush_op", 128'(op), '0);
    chk("flush_format", 128'(format), '0);
    chk("flush_reg_write", 128'(reg_write), '0);
    chk("flush_ra", ra, '0);
    idle_inputs();
    ra_addr = 7'd20;
    step();
    chk("flush_wb_commit", ra, PAT_11);

    // Back-to-back dependent instructions with a 4-cycle writeback pipe
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      wb_vld.push_back(1'b0); wb_addr.push_back('0); wb_data.push_back('0);
    end
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      rand_fields();
      rt_addr_in = 7'(40 + (i % 3));
      reg_write_in = (i < 12);
      ra_addr = 7'(40 + ((i + 2) % 3));
      rb_addr = 7'(40 + ((i + 1) % 3));
      rc_addr = 7'($urandom_range(38, 43));
      wb_vld.push_back(reg_write_in); wb_addr.push_back(rt_addr_in); wb_data.push_back(rnd128());
      if (i % 2 == 0) begin
        reg_write_even_wb = wb_vld.pop_front();
        rt_addr_even_wb = wb_addr.pop_front();
        rt_even_wb = wb_data.pop_front();
      end else begin
        reg_write_odd_wb = wb_vld.pop_front();
        rt_addr_odd_wb = wb_addr.pop_front();
        rt_odd_wb = wb_data.pop_front();
      end
      step();
    end

    // Randomized traffic over a small address window to force hits and conflicts
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      ra_addr = 7'($urandom_range(0, 15));
      rb_addr = 7'($urandom_range(0, 15));
      rc_addr = 7'($urandom_range(0, 15));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reg_write_even_wb = 1'($urandom());
      rt_addr_even_wb = 7'($urandom_range(0, 15));
      rt_even_wb = rnd128();
      reg_write_odd_wb = 1'($urandom());
      rt_addr_odd_wb = 7'($urandom_range(0, 15));
      rt_odd_wb = rnd128();
      step();
    end

    // Asynchronous reset in mid-cycle, with writebacks that must be discarded
    rand_fields();
    stall = 1'b1;
    reg_write_even_wb = 1'b1; rt_addr_even_wb = 7'd2; rt_even_wb = rnd128();
    reg_write_odd_wb = 1'b1; rt_addr_odd_wb = 7'd4; rt_odd_wb = rnd128();
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_async");
    step();
    step();
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      ra_addr = 7'($urandom_range(0, 15));
      rb_addr = 7'(i % 2 == 0 ? 2 : 4);
      rc_addr = 7'($urandom_range(0, 127));
      step();
      chk("post_reset_ra", ra, '0);
      chk("post_reset_rb", rb, '0);
    end

    @(posedge clk);
    #2;
    chk("sb_drained", 128'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spu_reg_fetch.md
# spu_reg_fetch

Register-file / operand-fetch (RF/FWD) stage of the SPU pipeline. It holds the 128 x 128-bit architectural register file, reads three source operands per instruction, bypasses same-cycle writebacks from the even and odd execution pipes, and registers operands plus decoded instruction fields into the execute units (SimpleFixed2 and its siblings). Writeback ports are driven directly by the execution units' `rt_wb` / `rt_addr_wb` / `reg_write_wb` outputs.

## Interface
- No parameters. Register count is fixed at 128 and data width at 128 bits. Bit ordering is big-endian: `[0:127]`, `[0:6]`, `[0:10]`, `[0:17]`.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ra_addr`, `rb_addr`, `rc_addr`  in  7 each  source register addresses from decode.
- `op_in`  in  11  decoded opcode, passed through.
- `format_in`  in  3  instruction format, passed through.
- `imm_in`  in  18  immediate, passed through.
- `rt_addr_in`  in  7  destination address, passed through.
- `reg_write_in`  in  1  destination-write flag, passed through.
- `stall`  in  1  hold the output register.
- `flush`  in  1  replace the output register with a nop.
- `rt_even_wb`  in  128  even-pipe writeback data.
- `rt_addr_even_wb`  in  7  even-pipe writeback address.
- `reg_write_even_wb`  in  1  even-pipe write enable.
- `rt_odd_wb`, `rt_addr_odd_wb`, `reg_write_odd_wb`  in  128 / 7 / 1  odd-pipe writeback, same meaning as the even port.
- `ra`, `rb`, `rc`  out  128 each  registered operands.
- `op`  out  11  registered pass-through of `op_in`.
- `format`  out  3  registered pass-through of `format_in`.
- `imm`  out  18  registered pass-through of `imm_in`.
- `rt_addr`  out  7  registered pass-through of `rt_addr_in`.
- `reg_write`  out  1  registered pass-through of `reg_write_in`.
- `wb_conflict`  out  1  registered flag: both writeback ports targeted the same address in the previous cycle.

## Operation
- **Register file write**
  - On each rising edge, a port with its enable high writes its data to its address.
  - If both ports are enabled with equal addresses, the odd port's data is written (the odd instruction is later in program order) and `wb_conflict` is 1 in the next cycle. Otherwise `wb_conflict` is 0.
  - Writes occur regardless of `stall` and `flush`.
- **Read with bypass, per operand**
  - Operand = odd data if `reg_write_odd_wb` is high and `rt_addr_odd_wb` equals the operand address.
  - Else even data if the even port is enabled and its address matches.
  - Else the array entry.
  - No register is hardwired; register 0 is general-purpose.
- **Output register update, one rising edge, priority order**
  1. `flush`: `op`, `format`, `imm`, `rt_addr`, `reg_write` and the three operands all load 0. This is the nop encoding `format == 0 && op == 0`. The stored source addresses also load 0.
  2. `stall` (no flush): instruction fields hold. Each operand refreshes from the bypass logic using its stored source address. Operands therefore never go stale while held.
  3. Otherwise: load the bypassed operands, the `*_in` fields, and the three source addresses into the stored-address registers.
- **Reset** (asynchronous, any time including mid-stall)
  - All 128 array entries clear to 0.
  - All outputs, including `wb_conflict`, and the stored addresses clear to 0.
  - Writebacks presented while `reset` is high are discarded.

## Timing
- Latency is one cycle. Addresses and fields presented in cycle N appear on the outputs after edge N+1.
- A writeback presented in cycle N is visible to a read issued in cycle N through the bypass, and from the array from cycle N+1.
- The first edge after `reset` deasserts performs a normal update.
- If `stall` and `flush` are both high, `flush` wins.
- `wb_conflict` asserts one cycle after the conflicting writes and lasts one cycle per conflicting cycle.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `reset` mid-cycle with random inputs → all outputs read 0 immediately. After release, reading any address returns 0.
- **Write then read:** write `128'hA5...A5` to r5 via even port in cycle 0; read `ra_addr=5` in cycle 1 → `ra == A5...A5` after the next edge. `rb_addr=6` → `rb == 0`.
- **Same-cycle bypass and priority:** even writes r9=`0x11..`, odd writes r9=`0x22..`, `rc_addr=9`, all in one cycle → `rc == 0x22..` after the edge and `wb_conflict == 1` for one cycle. Reading r9 later returns `0x22..`.
- **Stall refresh:** issue `ra_addr=3` (r3=0), assert `stall`, odd writes r3=`0xFF..` → `ra` updates to `0xFF..` while `op`, `imm`, `rt_addr` stay unchanged. Deassert `stall` → the next instruction loads normally.
- **Flush priority:** `stall=1`, `flush=1` with `op_in=11'b00001011111` (shlh), `reg_write_in=1` → the outputs become the nop encoding with `reg_write == 0`. A write presented in the same cycle still commits to the array.
- **Back-to-back pipeline:** three consecutive instructions, each reading the previous instruction's destination, driven by a writeback model with 4-cycle delay → every operand matches the reference model's register state at read time.
